// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with an auto-scan sequencer.
// Direct mode decodes sel; scan mode walks the index every PERIOD enabled cycles.
module scan_decoder #(
  parameter int N      = 2,
  parameter int PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        sel,
  input  logic                load,
  output logic [(1<<N)-1:0]   d,
  output logic [N-1:0]        cur,
  output logic                wrap
);

  localparam int              W        = 1 << N;
  localparam int              PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]   TMR_LOAD = PW'(PERIOD - 1);
  localparam logic [N-1:0]    IDX_LAST = '1;

  logic [N-1:0]  idx;
  logic [N-1:0]  idx_next;
  // Step timer counts down the cycles left in the current step; zero means a step is due.
  logic [PW-1:0] tmr;
  logic [PW-1:0] tmr_next;
  logic          wrap_next;

  always_comb begin
    idx_next  = idx;
    tmr_next  = tmr;
    wrap_next = 1'b0;
    if (en) begin
      if (load || !mode) begin
        idx_next = sel;
        tmr_next = TMR_LOAD;
      end else if (tmr == '0) begin
        idx_next  = idx + N'(1);
        tmr_next  = TMR_LOAD;
        wrap_next = (idx == IDX_LAST);
      end else begin
        tmr_next = tmr - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      tmr  <= TMR_LOAD;
      d    <= '0;
      wrap <= 1'b0;
    end else begin
      idx  <= idx_next;
      tmr  <= tmr_next;
      d    <= en ? (W'(1) << idx_next) : '0;
      wrap <= wrap_next;
    end
  end

  assign cur = idx;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios plus random stimulus
// compared against an integer reference model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       en_a, mode_a, load_a;
  logic [1:0] sel_a;
  logic [3:0] d_a;
  logic [1:0] cur_a;
  logic       wrap_a;

  logic       en_b, mode_b, load_b;
  logic [2:0] sel_b;
  logic [7:0] d_b;
  logic [2:0] cur_b;
  logic       wrap_b;

  int errors = 0;
  int checks = 0;

  // reference model state: index, enabled scan cycles since last step, outputs
  int ma_idx, ma_cnt, ma_wrap, ma_d;
  int mb_idx, mb_cnt, mb_wrap, mb_d;

  scan_decoder #(.N(2), .PERIOD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
    .load(load_a), .d(d_a), .cur(cur_a), .wrap(wrap_a)
  );

  scan_decoder #(.N(3), .PERIOD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
    .load(load_b), .d(d_b), .cur(cur_b), .wrap(wrap_b)
  );

  task automatic model_step(input int n, input int period, input logic en,
                            input logic mode, input logic load, input int sel,
                            inout int idx, inout int cnt, output int wr, output int dv);
    wr = 0;
    if (en) begin
      if (load || !mode) begin
        idx = sel;
        cnt = 0;
      end else begin
        cnt = cnt + 1;
        if (cnt == period) begin
          cnt = 0;
          idx = (idx + 1) % (1 << n);
          wr  = (idx == 0) ? 1 : 0;
        end
      end
    end
    dv = en ? (1 << idx) : 0;
  endtask

  task automatic model_reset();
    ma_idx = 0; ma_cnt = 0; ma_wrap = 0; ma_d = 0;
    mb_idx = 0; mb_cnt = 0; mb_wrap = 0; mb_d = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(2, 4, en_a, mode_a, load_a, int'(sel_a), ma_idx, ma_cnt, ma_wrap, ma_d);
      model_step(3, 1, en_b, mode_b, load_b, int'(sel_b), mb_idx, mb_cnt, mb_wrap, mb_d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 1'b1; mode_a = 1'b0; load_a = 1'b0; sel_a = 2'd3;
    en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; sel_b = 3'd0;
    model_reset();
    cycle();
    cycle();
    checks++;
    if (d_a !== 4'd0 || cur_a !== 2'd0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: d=%b cur=%0d wrap=%b, required 0/0/0", d_a, cur_a, wrap_a);
    end
    checks++;
    if (d_b !== 8'd0 || cur_b !== 3'd0 || wrap_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: d=%b cur=%0d wrap=%b, required 0/0/0", d_b, cur_b, wrap_b);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_direct();
    en_a = 1'b1; mode_a = 1'b0; load_a = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      cycle();
      checks++;
      if (d_a !== 4'(1 << s) || cur_a !== 2'(s) || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL direct sel=%0d: d=%b cur=%0d wrap=%b, required d=%b cur=%0d wrap=0",
                 s, d_a, cur_a, wrap_a, 4'(1 << s), s);
      end
    end
  endtask

  task automatic test_scan();
    int wraps;
    wraps = 0;
    en_a = 1'b1; mode_a = 1'b1; load_a = 1'b1; sel_a = 2'd0;
    cycle();
    load_a = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (wrap_a) wraps++;
      checks++;
      if (cur_a !== 2'((i / 4) % 4) || d_a !== 4'(1 << ((i / 4) % 4)) ||
          wrap_a !== ((i % 16) == 0)) begin
        errors++;
        $display("FAIL scan cycle %0d: cur=%0d d=%b wrap=%b, required cur=%0d wrap=%0d",
                 i, cur_a, d_a, wrap_a, (i / 4) % 4, (i % 16) == 0);
      end
    end
    checks++;
    if (wraps != 2) begin
      errors++;
      $display("FAIL scan_wrap_count: got %0d, required 2", wraps);
    end
  endtask

  task automatic test_en_gap();
    logic [1:0] cur0;
    int         n;
    en_a = 1'b1; mode_a = 1'b1; load_a = 1'b1; sel_a = 2'd1;
    cycle();
    load_a = 1'b0;
    cycle();
    cycle();
    cur0 = cur_a;
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (d_a !== 4'd0 || cur_a !== cur0 || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL en_gap %0d: d=%b cur=%0d, required d=0000 cur=%0d", i, d_a, cur_a, cur0);
      end
    end
    en_a = 1'b1;
    n = 0;
    while (cur_a === cur0 && n < 12) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 2 || cur_a !== cur0 + 2'd1 || d_a !== 4'(1 << (cur0 + 2'd1))) begin
      errors++;
      $display("FAIL en_gap_resume: step after %0d cycles to cur=%0d d=%b, required 2 cycles to cur=%0d",
               n, cur_a, d_a, cur0 + 2'd1);
    end
  endtask

  task automatic test_load_vs_step();
    en_a = 1'b1; mode_a = 1'b1; load_a = 1'b1; sel_a = 2'd3;
    cycle();
    load_a = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    load_a = 1'b1; sel_a = 2'd1;
    cycle();
    checks++;
    if (cur_a !== 2'd1 || d_a !== 4'b0010 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL load_vs_step: cur=%0d d=%b wrap=%b, required 1/0010/0", cur_a, d_a, wrap_a);
    end
    load_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++;
      if (cur_a !== ((i == 4) ? 2'd2 : 2'd1) || wrap_a !== 1'b0) begin
        errors++;
        $display("FAIL load_then_step %0d: cur=%0d wrap=%b, required cur=%0d wrap=0",
                 i, cur_a, wrap_a, (i == 4) ? 2 : 1);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    en_a = 1'b1; mode_a = 1'b1; load_a = 1'b1; sel_a = 2'd0;
    cycle();
    load_a = 1'b0;
    n = 0;
    while (cur_a !== 2'd2 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (cur_a !== 2'd2) begin
      errors++;
      $display("FAIL async_reset_setup: cur=%0d after %0d cycles, required 2", cur_a, n);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (d_a !== 4'd0 || cur_a !== 2'd0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: d=%b cur=%0d wrap=%b before clk, required 0/0/0", d_a, cur_a, wrap_a);
    end
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++;
      if (cur_a !== ((i == 4) ? 2'd1 : 2'd0) || d_a !== ((i == 4) ? 4'b0010 : 4'b0001)) begin
        errors++;
        $display("FAIL after_reset %0d: cur=%0d d=%b, required cur=%0d", i, cur_a, d_a, (i == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_n3_p1();
    en_b = 1'b1; mode_b = 1'b1; load_b = 1'b1; sel_b = 3'd0;
    cycle();
    load_b = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      cycle();
      checks++;
      if (cur_b !== 3'(i % 8) || d_b !== 8'(1 << (i % 8)) || wrap_b !== ((i % 8) == 0)) begin
        errors++;
        $display("FAIL n3_p1 cycle %0d: cur=%0d d=%b wrap=%b, required cur=%0d wrap=%0d",
                 i, cur_b, d_b, wrap_b, i % 8, (i % 8) == 0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en_a   = ($urandom_range(0, 7) != 0);
      mode_a = ($urandom_range(0, 3) != 0);
      load_a = ($urandom_range(0, 11) == 0);
      sel_a  = 2'($urandom);
      en_b   = ($urandom_range(0, 5) != 0);
      mode_b = ($urandom_range(0, 3) != 0);
      load_b = ($urandom_range(0, 9) == 0);
      sel_b  = 3'($urandom);
      cycle();
      checks++;
      if (d_a !== 4'(ma_d) || cur_a !== 2'(ma_idx) || wrap_a !== 1'(ma_wrap)) begin
        errors++;
        $display("FAIL random_a %0d: d=%b cur=%0d wrap=%b, required d=%b cur=%0d wrap=%0d",
                 i, d_a, cur_a, wrap_a, 4'(ma_d), ma_idx, ma_wrap);
      end
      checks++;
      if (d_b !== 8'(mb_d) || cur_b !== 3'(mb_idx) || wrap_b !== 1'(mb_wrap)) begin
        errors++;
        $display("FAIL random_b %0d: d=%b cur=%0d wrap=%b, required d=%b cur=%0d wrap=%0d",
                 i, d_b, cur_b, wrap_b, 8'(mb_d), mb_idx, mb_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_en_gap();
    test_load_vs_step();
    test_async_reset();
    test_n3_p1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
